// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS datapath: fetch FSM states, next-PC select codes
// and small word-address helpers used by the fetch stage.
package cpu_types_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned JIDX_W     = 26;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
    localparam logic [31:0] REGION_MSK = 32'hF000_0000;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        JSEL_SEQ = 2'b00,
        JSEL_BR  = 2'b01,
        JSEL_JR  = 2'b10,
        JSEL_J   = 2'b11
    } jumpsel_t;

    // Clears the byte-offset bits so any value becomes a legal PC.
    function automatic word_t word_align(input word_t addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch-stage signals, with one view for the fetch unit itself
// and one for a bench or neighbouring stage that drives decode results.
interface fetch_unit_if (
    input logic CLK
);

    logic                      RST;
    logic                      ihit;
    logic [31:0]               imemload;
    logic                      dhit;
    logic                      dmem_pending;
    cpu_types_pkg::jumpsel_t   JumpSel;
    logic                      branch_taken;
    logic [31:0]               ext_imm;
    logic [31:0]               rs_data;
    logic                      Halt;
    logic                      imemREN;
    logic [31:0]               imemaddr;
    logic [31:0]               Instr;
    logic                      instr_valid;
    logic [31:0]               pc_plus4;
    logic                      halt;

    modport fu (
        input  CLK, RST, ihit, imemload, dhit, dmem_pending, JumpSel,
               branch_taken, ext_imm, rs_data, Halt,
        output imemREN, imemaddr, Instr, instr_valid, pc_plus4, halt
    );

    modport tb (
        input  CLK, imemREN, imemaddr, Instr, instr_valid, pc_plus4, halt,
        output RST, ihit, imemload, dhit, dmem_pending, JumpSel,
               branch_taken, ext_imm, rs_data, Halt
    );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, PC-relative branch, register
// jump and pseudo-direct jump. All arithmetic wraps modulo 2^32.
module pc_next_logic
    import cpu_types_pkg::*;
(
    input  logic [31:0]       i_pc,
    input  jumpsel_t          i_jump_sel,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_ext_imm,
    input  logic [31:0]       i_rs_data,
    input  logic [JIDX_W-1:0] i_jidx,
    output logic [31:0]       o_pc_plus4,
    output logic [31:0]       o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_j_tgt;

    assign w_pc_plus4   = i_pc + WORD_BYTES;
    assign w_branch_tgt = w_pc_plus4 + (i_ext_imm << 2);
    assign w_jr_tgt     = word_align(i_rs_data);
    // Pseudo-direct jump keeps the 256 MB region of the delay-slot address.
    assign w_j_tgt      = {w_pc_plus4[31:28], i_jidx, 2'b00};

    assign o_pc_plus4 = w_pc_plus4;

    always_comb begin
        // NOTE: default assignment first so every path drives o_next_pc and no latch is inferred.
        o_next_pc = w_pc_plus4;
        unique case (i_jump_sel)
            JSEL_SEQ: o_next_pc = w_pc_plus4;
            JSEL_BR:  o_next_pc = i_branch_taken ? w_branch_tgt : w_pc_plus4;
            JSEL_JR:  o_next_pc = w_jr_tgt;
            JSEL_J:   o_next_pc = w_j_tgt;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the fetched-instruction latch and the
// FETCH/EXEC/HALTED sequencing that paces the single-cycle datapath.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic        dmem_pending,
    input  jumpsel_t    JumpSel,
    input  logic        branch_taken,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    input  logic        Halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic        halt
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_halt;

    logic [31:0]  w_next_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_dmem_wait;

    pc_next_logic u_pc_next (
        .i_pc           (r_pc),
        .i_jump_sel     (JumpSel),
        .i_branch_taken (branch_taken),
        .i_ext_imm      (ext_imm),
        .i_rs_data      (rs_data),
        .i_jidx         (r_instr[JIDX_W-1:0]),
        .o_pc_plus4     (w_pc_plus4),
        .o_next_pc      (w_next_pc)
    );

    assign w_dmem_wait = dmem_pending && !dhit;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and wins over any ihit in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= FETCH;
            r_pc          <= word_align(PC_INIT);
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (r_state)
                FETCH: begin
                    if (ihit) begin
                        r_instr       <= imemload;
                        r_instr_valid <= 1'b1;
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (Halt) begin
                        r_halt        <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_state       <= HALTED;
                    end else if (!w_dmem_wait) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                    end
                end
                HALTED: begin
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imemREN     = (r_state == FETCH);
    assign imemaddr    = r_pc;
    assign Instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_plus4    = w_pc_plus4;
    assign halt        = r_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit and its standalone pc_next_logic mux.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit_if fif (.CLK(clk));

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK          (fif.CLK),
        .RST          (fif.RST),
        .ihit         (fif.ihit),
        .imemload     (fif.imemload),
        .dhit         (fif.dhit),
        .dmem_pending (fif.dmem_pending),
        .JumpSel      (fif.JumpSel),
        .branch_taken (fif.branch_taken),
        .ext_imm      (fif.ext_imm),
        .rs_data      (fif.rs_data),
        .Halt         (fif.Halt),
        .imemREN      (fif.imemREN),
        .imemaddr     (fif.imemaddr),
        .Instr        (fif.Instr),
        .instr_valid  (fif.instr_valid),
        .pc_plus4     (fif.pc_plus4),
        .halt         (fif.halt)
    );

    // Standalone next-PC mux
    logic [31:0] p_pc, p_imm, p_rs, p_plus4, p_next;
    jumpsel_t    p_js;
    logic        p_bt;
    logic [25:0] p_jidx;

    pc_next_logic u_pnl (
        .i_pc           (p_pc),
        .i_jump_sel     (p_js),
        .i_branch_taken (p_bt),
        .i_ext_imm      (p_imm),
        .i_rs_data      (p_rs),
        .i_jidx         (p_jidx),
        .o_pc_plus4     (p_plus4),
        .o_next_pc      (p_next)
    );

    typedef struct {
        logic [31:0] pc;
        jumpsel_t    js;
        logic        bt;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [25:0] jidx;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        fif.ihit         = 1'b0;
        fif.dhit         = 1'b0;
        fif.dmem_pending = 1'b0;
        fif.Halt         = 1'b0;
        fif.branch_taken = 1'b0;
        fif.JumpSel      = JSEL_SEQ;
        fif.ext_imm      = '0;
        fif.rs_data      = '0;
    endtask

    // Expects FETCH; leaves the DUT in EXEC holding w.
    task automatic fetch(input logic [31:0] w);
        fif.ihit     = 1'b1;
        fif.imemload = w;
        step();
        fif.ihit     = 1'b0;
    endtask

    // Expects EXEC; retires the instruction without a data access.
    task automatic exec(input jumpsel_t js, input logic bt, input logic [31:0] imm, input logic [31:0] rs);
        fif.JumpSel      = js;
        fif.branch_taken = bt;
        fif.ext_imm      = imm;
        fif.rs_data      = rs;
        fif.dmem_pending = 1'b0;
        fif.Halt         = 1'b0;
        step();
        quiet_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] a);
        fetch(32'h0);
        exec(JSEL_JR, 1'b0, 32'h0, a);
    endtask

    // Next PC from the architectural rules, written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input int js, input logic bt,
                                             input logic [31:0] imm, input logic [31:0] rs,
                                             input logic [31:0] word);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (js)
            0:       return seq;
            1:       return bt ? seq + imm * 32'd4 : seq;
            2:       return rs - (rs % 32'd4);
            default: return (seq & 32'hF000_0000) + (word % 32'h0400_0000) * 32'd4;
        endcase
    endfunction

    initial begin
        logic [31:0] m_pc, word, imm, rs;
        logic        bt, pend;
        int          js, d, w;

        vecs[0] = '{32'h0000_0000, JSEL_SEQ, 1'b0, 32'h0,         32'h0,         26'h0,       32'h0000_0004};
        vecs[1] = '{32'hFFFF_FFFC, JSEL_SEQ, 1'b0, 32'h0,         32'h0,         26'h0,       32'h0000_0000};
        vecs[2] = '{32'h0000_0010, JSEL_BR,  1'b1, 32'hFFFF_FFFC, 32'h0,         26'h0,       32'h0000_0004};
        vecs[3] = '{32'h0000_0010, JSEL_BR,  1'b0, 32'hFFFF_FFFC, 32'h0,         26'h0,       32'h0000_0014};
        vecs[4] = '{32'h4000_0010, JSEL_J,   1'b0, 32'h0,         32'h0,         26'h100,     32'h4000_0400};
        vecs[5] = '{32'h0000_0000, JSEL_JR,  1'b0, 32'h0,         32'h0000_1237, 26'h0,       32'h0000_1234};
        vecs[6] = '{32'h0000_0100, JSEL_BR,  1'b1, 32'h0000_0003, 32'h0,         26'h0,       32'h0000_0110};
        vecs[7] = '{32'hEFFF_FFFC, JSEL_J,   1'b0, 32'h0,         32'h0,         26'h3FF_FFFF, 32'hFFFF_FFFC};
        vecs[8] = '{32'h0000_0008, JSEL_SEQ, 1'b1, 32'h0000_0040, 32'h0000_0100, 26'h0,       32'h0000_000C};
        vecs[9] = '{32'h0000_0020, JSEL_JR,  1'b1, 32'h0,         32'hFFFF_FFFF, 26'h0,       32'hFFFF_FFFC};

        for (int i = 0; i < 10; i++) begin
            p_pc = vecs[i].pc; p_js = vecs[i].js; p_bt = vecs[i].bt;
            p_imm = vecs[i].imm; p_rs = vecs[i].rs; p_jidx = vecs[i].jidx;
            #1;
            check($sformatf("pnl_next[%0d]", i), p_next, vecs[i].exp_next);
            check($sformatf("pnl_plus4[%0d]", i), p_plus4, vecs[i].pc + 32'd4);
        end

        // Reset held two cycles with ihit asserted
        quiet_inputs();
        fif.imemload = 32'hDEAD_BEEF;
        fif.RST  = 1'b1;
        fif.ihit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_addr",  fif.imemaddr, 32'h0);
            check("rst_ren",   32'(fif.imemREN), 32'h1);
            check("rst_valid", 32'(fif.instr_valid), 32'h0);
            check("rst_halt",  32'(fif.halt), 32'h0);
            check("rst_instr", fif.Instr, 32'h0);
        end
        fif.RST = 1'b0;

        // Sequential flow, each PC held for two cycles
        fif.ihit = 1'b1;
        fif.JumpSel = JSEL_SEQ;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("seq_addr[%0d]", k), fif.imemaddr, 32'(4 * (k / 2)));
            check($sformatf("seq_ren[%0d]", k), 32'(fif.imemREN), 32'(k % 2 == 0));
        end
        quiet_inputs();

        // Wrap-around through a misaligned JR target
        goto_pc(32'hFFFF_FFFF);
        check("jr_align_top", fif.imemaddr, 32'hFFFF_FFFC);
        check("plus4_wrap", fif.pc_plus4, 32'h0);
        fetch(32'h0);
        exec(JSEL_SEQ, 1'b0, 32'h0, 32'h0);
        check("seq_wrap", fif.imemaddr, 32'h0);

        // Branch taken / not taken
        goto_pc(32'h10);
        fetch(32'h1000_FFFF);
        exec(JSEL_BR, 1'b1, 32'hFFFF_FFFC, 32'h0);
        check("br_taken", fif.imemaddr, 32'h04);
        goto_pc(32'h10);
        fetch(32'h1000_FFFF);
        exec(JSEL_BR, 1'b0, 32'hFFFF_FFFC, 32'h0);
        check("br_not_taken", fif.imemaddr, 32'h14);

        // J and JR
        goto_pc(32'h4000_0010);
        fetch(32'h0800_0100);
        exec(JSEL_J, 1'b0, 32'h0, 32'h0);
        check("jump_j", fif.imemaddr, 32'h4000_0400);
        fetch(32'h0);
        exec(JSEL_JR, 1'b0, 32'h0, 32'h0000_1237);
        check("jump_jr", fif.imemaddr, 32'h0000_1234);

        // Data stall: three wait cycles then dhit
        fetch(32'h8C22_0004);
        fif.dmem_pending = 1'b1;
        fif.dhit = 1'b0;
        fif.ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  fif.imemaddr, 32'h0000_1234);
            check("stall_instr", fif.Instr, 32'h8C22_0004);
            check("stall_valid", 32'(fif.instr_valid), 32'h1);
            check("stall_ren",   32'(fif.imemREN), 32'h0);
        end
        fif.dhit = 1'b1;
        fif.ihit = 1'b0;
        step();
        check("stall_release_addr", fif.imemaddr, 32'h0000_1238);
        check("stall_release_ren",  32'(fif.imemREN), 32'h1);
        check("stall_release_valid", 32'(fif.instr_valid), 32'h0);
        quiet_inputs();

        // Reset from EXEC
        fetch(32'h1234_5678);
        fif.RST = 1'b1;
        step();
        fif.RST = 1'b0;
        check("midrst_addr", fif.imemaddr, 32'h0);
        check("midrst_ren",  32'(fif.imemREN), 32'h1);
        check("midrst_valid", 32'(fif.instr_valid), 32'h0);

        // Halt beats a pending data access, then stays frozen
        goto_pc(32'h20);
        fetch(32'hFC00_0000);
        fif.Halt = 1'b1;
        fif.dmem_pending = 1'b1;
        fif.dhit = 1'b0;
        step();
        check("halt_flag",  32'(fif.halt), 32'h1);
        check("halt_ren",   32'(fif.imemREN), 32'h0);
        check("halt_addr",  fif.imemaddr, 32'h20);
        check("halt_valid", 32'(fif.instr_valid), 32'h0);
        quiet_inputs();
        for (int i = 0; i < 12; i++) begin
            fif.ihit = i[0];
            fif.dhit = 1'b1;
            fif.Halt = 1'($urandom_range(0, 1));
            fif.JumpSel = JSEL_JR;
            fif.rs_data = 32'h0000_0800;
            step();
            check("halted_addr", fif.imemaddr, 32'h20);
            check("halted_flag", 32'(fif.halt), 32'h1);
            check("halted_ren",  32'(fif.imemREN), 32'h0);
        end
        quiet_inputs();
        fif.RST = 1'b1;
        step();
        fif.RST = 1'b0;
        check("unhalt_addr", fif.imemaddr, 32'h0);
        check("unhalt_flag", 32'(fif.halt), 32'h0);
        check("unhalt_ren",  32'(fif.imemREN), 32'h1);

        // Randomized instruction stream against the reference model
        m_pc = 32'h0;
        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, 2);
            for (int c = 0; c < d; c++) begin
                fif.ihit = 1'b0;
                fif.imemload = $urandom;
                fif.Halt = 1'($urandom_range(0, 1));
                fif.dhit = 1'($urandom_range(0, 1));
                step();
                check("rnd_fetch_addr", fif.imemaddr, m_pc);
                check("rnd_fetch_ren",  32'(fif.imemREN), 32'h1);
            end
            word = $urandom;
            fif.ihit = 1'b1;
            fif.imemload = word;
            step();
            check("rnd_instr", fif.Instr, word);
            check("rnd_valid", 32'(fif.instr_valid), 32'h1);
            check("rnd_exec_ren", 32'(fif.imemREN), 32'h0);

            js   = $urandom_range(0, 3);
            bt   = 1'($urandom_range(0, 1));
            imm  = $urandom;
            rs   = $urandom;
            pend = 1'($urandom_range(0, 1));
            w    = pend ? $urandom_range(0, 3) : 0;
            fif.JumpSel = jumpsel_t'(js[1:0]);
            fif.branch_taken = bt;
            fif.ext_imm = imm;
            fif.rs_data = rs;
            fif.dmem_pending = pend;
            fif.Halt = 1'b0;
            fif.imemload = $urandom;
            for (int c = 0; c < w; c++) begin
                fif.ihit = 1'($urandom_range(0, 1));
                fif.dhit = 1'b0;
                step();
                check("rnd_wait_addr",  fif.imemaddr, m_pc);
                check("rnd_wait_instr", fif.Instr, word);
            end
            fif.ihit = 1'($urandom_range(0, 1));
            fif.dhit = pend ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            m_pc = ref_next(m_pc, js, bt, imm, rs, word);
            check("rnd_next_addr", fif.imemaddr, m_pc);
            check("rnd_next_valid", 32'(fif.instr_valid), 32'h0);
            check("rnd_pc_plus4", fif.pc_plus4, m_pc + 32'd4);
            quiet_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
